// File: rtl/program_loader.sv
// Byte-stream loader for the 32x16 instruction memory.
// Holds the processor in reset until the image is written and its checksum matches.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Len,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [WORD_W-1:0] MemData,
    output logic              ProcReset,
    output logic              Busy,
    output logic              Done,
    output logic              ChkErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;

    logic              rx_ready_q, rx_ready_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic              proc_reset_q, proc_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              chk_err_q, chk_err_d;

    logic xfer;

    assign xfer = RxValid && rx_ready_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (Start) begin
                    len_d   = Len;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = RxData;
                    sum_d   = sum_q + RxData;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = RxData;
                    sum_d   = sum_q + RxData;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_q == len_q) begin
                    state_d = S_CHK;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_HI;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    state_d = (RxData == sum_q) ? S_RUN : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        rx_ready_d  = (state_d == S_HI) || (state_d == S_LO) ||
                      (state_d == S_CHK);
        mem_wr_en_d = (state_d == S_WRITE);
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        if (state_d == S_WRITE) begin
            mem_addr_d = idx_d;
            mem_data_d = WORD_W'({hi_d, lo_d});
        end
        busy_d    = rx_ready_d || mem_wr_en_d;
        done_d    = (state_d == S_RUN);
        chk_err_d = (state_d == S_ERR);
        // Processor reset trails the RUN state by one edge.
        proc_reset_d = (state_q != S_RUN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            rx_ready_q   <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            proc_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            chk_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            rx_ready_q   <= rx_ready_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            proc_reset_q <= proc_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            chk_err_q    <= chk_err_d;
        end
    end

    assign RxReady   = rx_ready_q;
    assign MemWrEn   = mem_wr_en_q;
    assign MemAddr   = mem_addr_q;
    assign MemData   = mem_data_q;
    assign ProcReset = proc_reset_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ChkErr    = chk_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Expected memory writes come from a queue filled as the stream is sent.
module tb_program_loader;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [4:0] Len;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;
    logic       MemWrEn;
    logic [4:0] MemAddr;
    logic [15:0] MemData;
    logic       ProcReset;
    logic       Busy;
    logic       Done;
    logic       ChkErr;

    program_loader #(.ADDR_W(5), .WORD_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemData(MemData),
        .ProcReset(ProcReset), .Busy(Busy), .Done(Done),
        .ChkErr(ChkErr)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    logic [20:0] exp_q[$];
    logic [15:0] words[32];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Per-cycle scoreboard: every write must be the next expected one.
    always @(negedge Clk) begin
        if (MemWrEn === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none",
                         MemAddr, MemData);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, MemAddr}, {27'd0, e[20:16]});
                chk("wr_data", {16'd0, MemData}, {16'd0, e[15:0]});
            end
            chk("rxready_in_write", {31'd0, RxReady}, 32'd0);
        end
        chk("done_chkerr_excl", {31'd0, Done && ChkErr}, 32'd0);
    end

    function automatic logic [7:0] sum8(input int len);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i <= len; i++) begin
            s = s + words[i][15:8];
            s = s + words[i][7:0];
        end
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps,
                             input bit hold);
        int t;
        if (!hold) begin
            RxValid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge Clk);
        end
        RxData  = b;
        RxValid = 1'b1;
        t = 0;
        while (RxReady !== 1'b1 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (RxReady !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got RxReady %b want 1", RxReady);
        end
        @(negedge Clk);
        if (!hold) RxValid = 1'b0;
    endtask

    task automatic do_start(input int l);
        Len   = 5'(l);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic load_body(input int len, input logic [7:0] ck_xor,
                             input bit gaps);
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back({5'(i), words[i]});
            send_byte(words[i][15:8], gaps, !gaps);
            send_byte(words[i][7:0], gaps, !gaps);
        end
        send_byte(sum8(len) ^ ck_xor, gaps, !gaps);
        RxValid = 1'b0;
        @(negedge Clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_procreset"}, {31'd0, ProcReset}, 32'd1);
        chk({tag, "_rxready"}, {31'd0, RxReady}, 32'd0);
        chk({tag, "_memwren"}, {31'd0, MemWrEn}, 32'd0);
        chk({tag, "_memaddr"}, {27'd0, MemAddr}, 32'd0);
        chk({tag, "_memdata"}, {16'd0, MemData}, 32'd0);
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, Done}, 32'd0);
        chk({tag, "_chkerr"}, {31'd0, ChkErr}, 32'd0);
    endtask

    initial begin
        int w0;
        Reset = 1'b1; Start = 1'b0; Len = '0;
        RxData = '0; RxValid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk_reset_vals("rst");

        RxValid = 1'b1;
        RxData = 8'h55;
        repeat (3) @(negedge Clk);
        chk("idle_rxready", {31'd0, RxReady}, 32'd0);
        RxValid = 1'b0;

        // Single word, exact cycle timeline with RxValid held high.
        w0 = n_wr;
        exp_q.push_back({5'd0, 16'h1234});
        do_start(0);
        chk("sw_rxready_hi", {31'd0, RxReady}, 32'd1);
        chk("sw_busy", {31'd0, Busy}, 32'd1);
        RxData = 8'h12; RxValid = 1'b1;
        @(negedge Clk);
        chk("sw_rxready_lo", {31'd0, RxReady}, 32'd1);
        RxData = 8'h34;
        @(negedge Clk);
        chk("sw_write", {31'd0, MemWrEn}, 32'd1);
        RxData = 8'h46;
        @(negedge Clk);
        chk("sw_chk_ready", {31'd0, RxReady}, 32'd1);
        chk("sw_chk_nowr", {31'd0, MemWrEn}, 32'd0);
        @(negedge Clk);
        chk("sw_done", {31'd0, Done}, 32'd1);
        chk("sw_busy_off", {31'd0, Busy}, 32'd0);
        chk("sw_procreset_lag", {31'd0, ProcReset}, 32'd1);
        RxValid = 1'b0;
        @(negedge Clk);
        chk("sw_procreset_low", {31'd0, ProcReset}, 32'd0);
        chk("sw_nwr", n_wr - w0, 1);

        // Three words, no gaps.
        words[0] = 16'hA001; words[1] = 16'h1234; words[2] = 16'hFFFF;
        chk("model_sum3", {24'd0, sum8(2)}, 32'hE5);
        w0 = n_wr;
        do_start(2);
        load_body(2, 8'h00, 1'b0);
        @(negedge Clk);
        chk("w3_done", {31'd0, Done}, 32'd1);
        chk("w3_chkerr", {31'd0, ChkErr}, 32'd0);
        chk("w3_procreset", {31'd0, ProcReset}, 32'd0);
        chk("w3_nwr", n_wr - w0, 3);

        // Bad checksum started from RUN.
        do_start(2);
        chk("bad_done_clr", {31'd0, Done}, 32'd0);
        chk("bad_busy", {31'd0, Busy}, 32'd1);
        chk("bad_procreset_lag", {31'd0, ProcReset}, 32'd0);
        load_body(2, 8'h01, 1'b0);
        @(negedge Clk);
        chk("bad_chkerr", {31'd0, ChkErr}, 32'd1);
        chk("bad_done", {31'd0, Done}, 32'd0);
        chk("bad_procreset", {31'd0, ProcReset}, 32'd1);

        // Recover from ERR with a gapped stream.
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        w0 = n_wr;
        do_start(7);
        chk("rec_chkerr_clr", {31'd0, ChkErr}, 32'd0);
        load_body(7, 8'h00, 1'b1);
        @(negedge Clk);
        chk("rec_done", {31'd0, Done}, 32'd1);
        chk("rec_chkerr", {31'd0, ChkErr}, 32'd0);
        chk("rec_nwr", n_wr - w0, 8);

        // Full memory, word value equals its address.
        for (int i = 0; i < 32; i++) words[i] = 16'(i);
        chk("model_sum32", {24'd0, sum8(31)}, 32'hF0);
        w0 = n_wr;
        do_start(31);
        load_body(31, 8'h00, 1'b0);
        repeat (4) @(negedge Clk);
        chk("full_done", {31'd0, Done}, 32'd1);
        chk("full_procreset", {31'd0, ProcReset}, 32'd0);
        chk("full_nwr", n_wr - w0, 32);
        chk("full_q_empty", exp_q.size(), 0);

        // Reset after three words of a six-word load.
        for (int i = 0; i < 6; i++) words[i] = 16'h0F00 + 16'(i);
        w0 = n_wr;
        do_start(5);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({5'(i), words[i]});
            send_byte(words[i][15:8], 1'b0, 1'b1);
            send_byte(words[i][7:0], 1'b0, 1'b1);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk_reset_vals("mid");
        RxData = 8'hAA; RxValid = 1'b1;
        repeat (10) @(negedge Clk);
        chk("mid_nwr", n_wr - w0, 3);
        chk("mid_q_empty", exp_q.size(), 0);
        chk("mid_rxready", {31'd0, RxReady}, 32'd0);
        RxValid = 1'b0;

        // Reset wins over a simultaneous Start.
        Reset = 1'b1; Start = 1'b1; Len = 5'd3;
        @(negedge Clk);
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clk);
        chk("rst_over_start_busy", {31'd0, Busy}, 32'd0);
        chk("rst_over_start_rdy", {31'd0, RxReady}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
